sequential_multiplier_128bit: RTL and testbench



---
 rtl/rsa_pkg.sv | 20 ++
 rtl/rsa_cond_add.sv | 13 +
 rtl/sequential_multiplier_128bit.sv | 86 ++++++++
 tb/tb_sequential_multiplier_128bit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath engines (multiplier and divider).
// Both engines use the same handshake: a reset_n-low edge loads operands, and done rises when the result is ready.
package rsa_pkg;

  localparam int RSA_WIDTH = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } rsa_state_e;

  // reset_n level that loads new operands and restarts an engine
  localparam logic RSA_LOAD_LEVEL = 1'b0;

  function automatic int rsa_cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/rsa_cond_add.sv
// Adds y into x when en is high. The add is WIDTH+1 bits wide so the carry stays in the sum.
module rsa_cond_add #(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH:0]   x,
  input  logic [WIDTH-1:0] y,
  input  logic             en,
  output logic [WIDTH:0]   sum
);

  assign sum = en ? (x + {1'b0, y}) : x;

endmodule

// File: rtl/sequential_multiplier_128bit.sv
// Radix-2 shift-and-add multiplier. It retires one multiplier bit per clock and has a fixed latency of WIDTH cycles.
// A low reset_n edge loads a and b and restarts the operation.
module sequential_multiplier_128bit
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p,
  output logic               done
);

  localparam int CW = rsa_cnt_width(WIDTH);

  rsa_state_e         state_reg = IDLE;
  rsa_state_e         state_next;
  logic [WIDTH-1:0]   a_reg = '0;
  logic [2*WIDTH:0]   acc_reg = '0;
  logic [2*WIDTH:0]   acc_next;
  logic [CW-1:0]      cnt_reg = '0;
  logic [CW-1:0]      cnt_next;
  logic [2*WIDTH-1:0] p_reg = '0;
  logic [2*WIDTH-1:0] p_next;
  logic               done_reg = 1'b0;
  logic               done_next;

  logic [WIDTH:0]     upper_sum;
  logic [2*WIDTH:0]   acc_shift;

  rsa_cond_add #(
    .WIDTH(WIDTH)
  ) u_cond_add (
    .x  (acc_reg[2*WIDTH:WIDTH]),
    .y  (a_reg),
    .en (acc_reg[0]),
    .sum(upper_sum)
  );

  // The multiplier bit just consumed shifts out of the bottom of the accumulator.
  assign acc_shift = {1'b0, upper_sum, acc_reg[WIDTH-1:1]};

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    p_next     = p_reg;
    done_next  = done_reg;
    case (state_reg)
      BUSY: begin
        acc_next = acc_shift;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CW'(WIDTH - 1)) begin
          p_next     = acc_shift[2*WIDTH-1:0];
          done_next  = 1'b1;
          state_next = DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n == RSA_LOAD_LEVEL) begin
      a_reg     <= a;
      acc_reg   <= {{(WIDTH + 1){1'b0}}, b};
      cnt_reg   <= '0;
      p_reg     <= '0;
      done_reg  <= 1'b0;
      state_reg <= BUSY;
    end else begin
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      p_reg     <= p_next;
      done_reg  <= done_next;
      state_reg <= state_next;
    end
  end

  // Gating done with reset_n keeps a stale done from being seen on a load edge.
  assign done = done_reg & reset_n;
  assign p    = p_reg;

endmodule

// File: tb/tb_sequential_multiplier_128bit.sv
// Directed-vector bench for sequential_multiplier_128bit: it checks latency, product, hold, abort and operand isolation.
module tb_sequential_multiplier_128bit;

  localparam int W = 128;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic [2*W-1:0]   p;
  logic             done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sequential_multiplier_128bit #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .a      (a),
    .b      (b),
    .p      (p),
    .done   (done)
  );

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // The load edge L is the posedge between the two negedges below. The task returns at the negedge after L.
  task automatic load(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    reset_n = 1'b0;
    #1;
    check({tag, "_done_while_load"}, {255'd0, done}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check({tag, "_p_after_load"}, p, '0);
    check({tag, "_done_after_load"}, {255'd0, done}, '0);
  endtask

  // It runs edges L+1..L+WIDTH and requires done to rise exactly at L+WIDTH.
  task automatic wait_done(input string tag, input logic [2*W-1:0] exp, input bit scramble);
    int early;
    early = 0;
    for (int i = 1; i < W; i++) begin
      if (scramble) begin
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      if (done !== 1'b0) early++;
    end
    check({tag, "_done_early_count"}, 256'(early), '0);
    @(negedge clk);
    check({tag, "_done_at_L+W"}, {255'd0, done}, 256'd1);
    check({tag, "_p"}, p, exp);
  endtask

  task automatic hold(input string tag, input logic [2*W-1:0] exp, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done !== 1'b1 || p !== exp) bad++;
    end
    check({tag, "_hold_bad_cycles"}, 256'(bad), '0);
  endtask

  initial begin
    logic [2*W-1:0] max_sq;
    max_sq = {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 128'h0000_0000_0000_0000_0000_0000_0000_0001};

    // 1: small product, then hold for 10 cycles
    load("t1", 128'd3, 128'd5);
    wait_done("t1", 256'd15, 1'b0);
    hold("t1", 256'd15, 10);

    // 2: largest operands
    load("t2", {W{1'b1}}, {W{1'b1}});
    wait_done("t2", max_sq, 1'b0);

    // 3: a zero operand still takes full latency
    load("t3a", 128'd0, 128'hDEADBEEF);
    wait_done("t3a", 256'd0, 1'b0);
    load("t3b", 128'd1, 128'hDEADBEEF);
    wait_done("t3b", 256'hDEADBEEF, 1'b0);

    // 4: abort at L+50 and restart with new operands
    load("t4a", 128'd7, 128'd9);
    repeat (48) @(negedge clk);
    check("t4_done_before_abort", {255'd0, done}, '0);
    load("t4b", 128'd11, 128'd13);
    wait_done("t4b", 256'd143, 1'b0);

    // 5: inputs change every cycle after the load, then back-to-back operations
    load("t5a", 128'd6, 128'd7);
    wait_done("t5a", 256'd42, 1'b1);
    load("t5b", 128'd12345, 128'd678);
    wait_done("t5b", 256'd8369910, 1'b0);
    load("t5c", 128'd1 << 127, 128'd2);
    wait_done("t5c", 256'd1 << 128, 1'b0);
    hold("t5c", 256'd1 << 128, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // A hung bench is reported through the summary line.
  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
